// File: rtl/pcs_tx_pkg.sv
// Shared PCS TX definitions: K-code symbol values and the SKP inserter FSM state type.
package pcs_tx_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [7:0] IDL_SYM = 8'h00;

  // Holds a SKP index for SKP_COUNT up to 5.
  localparam int SKP_CNT_W = 3;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    SEND_COM = 2'd1,
    SEND_SKP = 2'd2
  } skp_state_t;

endpackage

// File: rtl/skp_os_inserter_if.sv
// Upstream symbol stream into the SKP inserter.
// A symbol moves only in a cycle where in_valid and in_ready are both 1; in_ready may depend on
// in_valid/in_boundary in the same cycle, and the master holds a refused symbol until accepted.
interface skp_os_inserter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_k;
  logic                  in_valid;
  logic                  in_boundary;
  logic                  in_ready;

  modport master (output in_data, output in_k, output in_valid, output in_boundary,
                  input  in_ready);
  modport slave  (input  in_data, input  in_k, input  in_valid, input  in_boundary,
                  output in_ready);
endinterface

// File: rtl/skp_interval_timer.sv
// Saturating SKP interval counter; expire stays set from the last count until clear.
module skp_interval_timer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = $clog2(SKP_INTERVAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             force_set,
  output logic             expire,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SKP_INTERVAL - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else begin
      if (count != LAST) begin
        count <= count + 1'b1;
      end
      // Expire rises together with the count reaching LAST, keeping start-to-start at SKP_INTERVAL.
      if (force_set || (count == LAST - 1'b1)) begin
        expire <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/skp_os_inserter.sv
// PCS TX SKP ordered-set inserter: COM + SKP_COUNT SKPs every SKP_INTERVAL symbols, at packet boundaries.
// Optional SKP_FORCE_EN adds a force_skp input that requests an insert immediately.
module skp_os_inserter
  import pcs_tx_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_W        = $clog2(SKP_INTERVAL)
) (
  input  logic                  pclk,
  input  logic                  rst,
`ifdef SKP_FORCE_EN
  input  logic                  force_skp,
`endif
  skp_os_inserter_if.slave      up,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_k,
  output logic                  skp_sent,
  output logic                  skp_pending,
  output skp_state_t            state,
  output logic [CNT_W-1:0]      count
);

  localparam logic [SKP_CNT_W-1:0] SKP_LAST = SKP_CNT_W'(SKP_COUNT - 1);

  skp_state_t            state_q, state_d;
  logic [SKP_CNT_W-1:0]  skp_cnt_q, skp_cnt_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  k_d;
  logic                  sent_d;
  logic                  pending;
  logic                  force_ok;
  logic                  start;

`ifdef SKP_FORCE_EN
  assign force_ok = force_skp & (state_q == PASS);
`else
  assign force_ok = 1'b0;
`endif

  // The insert may only begin where no packet is in flight: idle input or a first symbol.
  assign start = (state_q == PASS) & (pending | force_ok) & (~up.in_valid | up.in_boundary);
  assign up.in_ready = ~rst & (state_q == PASS) & ~start;

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (pclk),
    .rst       (rst),
    .clear     (start),
    .force_set (force_ok),
    .expire    (pending),
    .count     (count)
  );

  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    data_d    = DATA_WIDTH'(IDL_SYM);
    k_d       = 1'b0;
    sent_d    = 1'b0;
    unique case (state_q)
      PASS: begin
        if (start) begin
          state_d = SEND_COM;
        end else if (up.in_valid) begin
          data_d = up.in_data;
          k_d    = up.in_k;
        end
      end
      SEND_COM: begin
        data_d    = DATA_WIDTH'(COM_SYM);
        k_d       = 1'b1;
        sent_d    = 1'b1;
        skp_cnt_d = '0;
        state_d   = SEND_SKP;
      end
      SEND_SKP: begin
        data_d = DATA_WIDTH'(SKP_SYM);
        k_d    = 1'b1;
        if (skp_cnt_q == SKP_LAST) begin
          skp_cnt_d = '0;
          state_d   = PASS;
        end else begin
          skp_cnt_d = skp_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= PASS;
      skp_cnt_q <= '0;
      out_data  <= '0;
      out_k     <= 1'b0;
      skp_sent  <= 1'b0;
    end else begin
      state_q   <= state_d;
      skp_cnt_q <= skp_cnt_d;
      out_data  <= data_d;
      out_k     <= k_d;
      skp_sent  <= sent_d;
    end
  end

  assign skp_pending = pending;
  assign state       = state_q;

endmodule
